sigpulse_seq: RTL and testbench
===============================

# sigpulse_seq

Pulse-train sequencer placed in front of one `sigpulse` instance. It latches a burst configuration (pulse width, inter-pulse gap, pulse count, idle level) on a start request. It then issues single-cycle triggers to `sigpulse`, paced by that block's `pulse_valid` handshake, until the burst completes or is stopped. It replaces the ad-hoc edge-detected `io_en` drive with a deterministic, countable pulse schedule.

## Interface
Parameters:
- `_RAM_WIDTH`, 32, width of pulse-width and gap fields (matches `sigpulse`)
- `CNT_WIDTH`, 16, width of pulse-count field and index

Ports:
- `io_clk`  in  1  system clock
- `io_rst`  in  1  reset, synchronous, active-high
- `io_start`  in  1  burst request; sampled only in IDLE
- `io_stop`  in  1  abort request; any state
- `io_pulseWidth`  in  `_RAM_WIDTH`  pulse width in clocks, latched on accepted start
- `io_gap`  in  `_RAM_WIDTH`  idle clocks between the end of one pulse and the next trigger, latched on start
- `io_count`  in  `CNT_WIDTH`  pulses per burst, latched on start
- `io_defaultLevel`  in  1  idle level, latched on start
- `sp_en`  out  1  one-cycle trigger to `sigpulse.io_en`
- `sp_pulseWidth`  out  `_RAM_WIDTH`  latched width to `sigpulse.io_pulseWidth`
- `sp_defaultLevel`  out  1  latched level to `sigpulse.io_defaultLevel`
- `sp_pulseValid`  in  1  from `sigpulse.pulse_valid`; high while a pulse is in progress
- `io_busy`  out  1  high in every state except IDLE
- `io_done`  out  1  one-cycle strobe on natural burst completion
- `io_pulseIdx`  out  `CNT_WIDTH`  number of triggers issued in the current or last burst

## Operation
- States: IDLE, FIRE, WAIT_HI, WAIT_LO, GAP, DRAIN.
- **IDLE:**
  - Accept `io_start` when `io_pulseWidth != 0` and the count is valid (see Configuration). Otherwise ignore it.
  - On accept: latch all config, clear `io_pulseIdx`, go to FIRE.
- **FIRE:**
  - `sp_en = 1` for exactly this one cycle.
  - Increment `io_pulseIdx`.
  - Go to WAIT_HI.
- **WAIT_HI:** wait for `sp_pulseValid = 1`, then go to WAIT_LO.
- **WAIT_LO:** wait for `sp_pulseValid = 0`. Then:
  - If `io_pulseIdx == count`: go to IDLE and pulse `io_done`.
  - Else if gap = 0: go to FIRE.
  - Else: load the gap counter with the gap value and go to GAP.
- **GAP:** decrement the gap counter each cycle; go to FIRE when it reaches 1. GAP therefore lasts exactly gap cycles.
- **Stop:**
  - `io_stop` in FIRE or GAP: go to IDLE.
  - `io_stop` in WAIT_HI or WAIT_LO: go to DRAIN. DRAIN waits for `sp_pulseValid = 0`, then goes to IDLE. An in-flight pulse is never truncated.
  - No `io_done` is issued on a stopped burst.
- **Priority:** `io_stop` beats `io_start` in the same cycle, so the start is dropped. `io_start` while busy is ignored.
- **Output hold:** `sp_pulseWidth` and `sp_defaultLevel` hold their latched values until the next accepted start.
- **Counter width:** `io_pulseIdx` width is `CNT_WIDTH`; the compare uses the latched count, so there is no wrap within a legal burst.

## Timing
- Reset values: state IDLE; `sp_en` 0; `sp_pulseWidth` 0; `sp_defaultLevel` 0; `io_busy` 0; `io_done` 0; `io_pulseIdx` 0.
- All outputs are registered.
- Start latency: `io_start` sampled high at edge N puts FIRE in cycle N+1, so `sp_en` is high in cycle N+1 and `io_busy` is high from N+1.
- Trigger spacing: sigpulse pulse length + gap + handshake overhead. Exact overhead is 1 cycle (WAIT_LO→FIRE/GAP) plus the sigpulse response latency.
- `io_done` is high in the single cycle in which the state is IDLE following the last WAIT_LO exit. `io_busy` is 0 in that same cycle.
- `io_rst` mid-burst: on the next edge, state and all outputs return to reset values. `sp_en` is never asserted in the reset cycle.

## Configuration
- Macro `SIGPULSE_SEQ_LOOP_EN`.
- **Defined:** `io_count == 0` at start means continuous mode.
  - WAIT_LO never exits to IDLE; the burst runs until `io_stop`.
  - `io_pulseIdx` wraps modulo 2^`CNT_WIDTH`.
  - `io_done` is never pulsed in this mode.
- **Undefined:** `io_start` with `io_count == 0` is ignored; the block stays in IDLE with `io_busy` 0.

## Test plan
- Reset, then start with width=100, gap=0, count=1, level=1 -> `sp_en` exactly 1 cycle at N+1, one sigpulse pulse, `io_done` once, `io_pulseIdx`=1.
- Start with count=3, gap=20 -> exactly 3 `sp_en` strobes; each trigger follows `pulse_valid` fall by 21 cycles; `io_done` after the third pulse.
- Assert `io_stop` during the 2nd pulse (WAIT_LO) of count=5 -> DRAIN until `pulse_valid` falls, then IDLE; no `io_done`; `io_pulseIdx`=2.
- `io_start` and `io_stop` in the same cycle, and `io_start` while busy -> no state change, no extra `sp_en`.
- Start with width=0 -> ignored. Start with count=0 -> ignored without `SIGPULSE_SEQ_LOOP_EN`; with the macro, it runs continuously until stop.
- Assert `io_rst` in GAP -> all outputs at reset values next cycle; a new start then behaves like the first scenario.

Source files
------------

// File: rtl/sigpulse_seq.sv
// Burst sequencer driving one sigpulse: latches a burst configuration on start and
// issues paced single-cycle triggers. Optional continuous mode: SIGPULSE_SEQ_LOOP_EN.
module sigpulse_seq #(
  parameter int _RAM_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  io_clk,
  input  logic                  io_rst,
  input  logic                  io_start,
  input  logic                  io_stop,
  input  logic [_RAM_WIDTH-1:0] io_pulseWidth,
  input  logic [_RAM_WIDTH-1:0] io_gap,
  input  logic [CNT_WIDTH-1:0]  io_count,
  input  logic                  io_defaultLevel,
  output logic                  sp_en,
  output logic [_RAM_WIDTH-1:0] sp_pulseWidth,
  output logic                  sp_defaultLevel,
  input  logic                  sp_pulseValid,
  output logic                  io_busy,
  output logic                  io_done,
  output logic [CNT_WIDTH-1:0]  io_pulseIdx
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FIRE    = 3'd1,
    S_WAIT_HI = 3'd2,
    S_WAIT_LO = 3'd3,
    S_GAP     = 3'd4,
    S_DRAIN   = 3'd5
  } state_t;

  state_t                  state_p0;
  state_t                  state_nxt;
  logic [_RAM_WIDTH-1:0]   gap_lat_p0;
  logic [_RAM_WIDTH-1:0]   gap_cnt_p0;
  logic [CNT_WIDTH-1:0]    cnt_lat_p0;
  logic                    start_ok;
  logic                    burst_end;
  logic                    accept;
  logic                    load_gap;
  logic                    sp_en_nxt;
  logic                    busy_nxt;
  logic                    done_nxt;
  logic [CNT_WIDTH-1:0]    idx_nxt;

`ifdef SIGPULSE_SEQ_LOOP_EN
  // A latched count of zero means run until stopped.
  assign start_ok  = (io_pulseWidth != '0);
  assign burst_end = (cnt_lat_p0 != '0) && (io_pulseIdx == cnt_lat_p0);
`else
  assign start_ok  = (io_pulseWidth != '0) && (io_count != '0);
  assign burst_end = (io_pulseIdx == cnt_lat_p0);
`endif

  // ---- state register and registered outputs
  always_ff @(posedge io_clk) begin
    if (io_rst) begin
      state_p0        <= S_IDLE;
      sp_en           <= 1'b0;
      io_busy         <= 1'b0;
      io_done         <= 1'b0;
      io_pulseIdx     <= '0;
      sp_pulseWidth   <= '0;
      sp_defaultLevel <= 1'b0;
    end else begin
      state_p0    <= state_nxt;
      sp_en       <= sp_en_nxt;
      io_busy     <= busy_nxt;
      io_done     <= done_nxt;
      io_pulseIdx <= idx_nxt;
      if (accept) begin
        sp_pulseWidth   <= io_pulseWidth;
        sp_defaultLevel <= io_defaultLevel;
      end
    end
  end

  // ---- burst configuration and gap timer (data path, no reset)
  always_ff @(posedge io_clk) begin
    if (accept) begin
      gap_lat_p0 <= io_gap;
      cnt_lat_p0 <= io_count;
    end
    if (load_gap) begin
      gap_cnt_p0 <= gap_lat_p0;
    end else if (state_p0 == S_GAP) begin
      gap_cnt_p0 <= gap_cnt_p0 - _RAM_WIDTH'(1);
    end
  end

  // ---- next-state logic
  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      S_IDLE: begin
        if (io_start && !io_stop && start_ok) state_nxt = S_FIRE;
      end
      S_FIRE: begin
        state_nxt = io_stop ? S_IDLE : S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (io_stop)            state_nxt = S_DRAIN;
        else if (sp_pulseValid) state_nxt = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (io_stop)                   state_nxt = S_DRAIN;
        else if (!sp_pulseValid) begin
          if (burst_end)               state_nxt = S_IDLE;
          else if (gap_lat_p0 == '0)   state_nxt = S_FIRE;
          else                         state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (io_stop)                                 state_nxt = S_IDLE;
        else if (gap_cnt_p0 == _RAM_WIDTH'(1))       state_nxt = S_FIRE;
      end
      S_DRAIN: begin
        if (!sp_pulseValid) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---- output logic, computed one cycle ahead so every output is a flop
  always_comb begin
    accept    = (state_p0 == S_IDLE) && (state_nxt == S_FIRE);
    load_gap  = (state_p0 == S_WAIT_LO) && (state_nxt == S_GAP);
    sp_en_nxt = (state_nxt == S_FIRE);
    busy_nxt  = (state_nxt != S_IDLE);
    // Only the natural WAIT_LO exit reaches IDLE directly; stops go through DRAIN or skip it.
    done_nxt  = (state_p0 == S_WAIT_LO) && (state_nxt == S_IDLE);
    idx_nxt   = io_pulseIdx;
    if (accept)                 idx_nxt = CNT_WIDTH'(1);
    else if (state_nxt == S_FIRE) idx_nxt = io_pulseIdx + CNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_sigpulse_seq.sv
// Scoreboard bench for sigpulse_seq with a behavioural sigpulse model; expected
// trigger/done events are queued by the driver and checked by a negedge monitor.
module tb_sigpulse_seq;
  localparam int W = 32;
  localparam int C = 16;
  localparam int EV_EN   = 0;
  localparam int EV_DONE = 1;

  logic         io_clk = 1'b0;
  logic         io_rst = 1'b1;
  logic         io_start = 1'b0;
  logic         io_stop = 1'b0;
  logic [W-1:0] io_pulseWidth = '0;
  logic [W-1:0] io_gap = '0;
  logic [C-1:0] io_count = '0;
  logic         io_defaultLevel = 1'b0;
  logic         sp_en;
  logic [W-1:0] sp_pulseWidth;
  logic         sp_defaultLevel;
  logic         sp_pulseValid;
  logic         io_busy;
  logic         io_done;
  logic [C-1:0] io_pulseIdx;

  sigpulse_seq #(._RAM_WIDTH(W), .CNT_WIDTH(C)) dut (
    .io_clk(io_clk), .io_rst(io_rst), .io_start(io_start), .io_stop(io_stop),
    .io_pulseWidth(io_pulseWidth), .io_gap(io_gap), .io_count(io_count),
    .io_defaultLevel(io_defaultLevel), .sp_en(sp_en), .sp_pulseWidth(sp_pulseWidth),
    .sp_defaultLevel(sp_defaultLevel), .sp_pulseValid(sp_pulseValid),
    .io_busy(io_busy), .io_done(io_done), .io_pulseIdx(io_pulseIdx)
  );

  always #5 io_clk = ~io_clk;

  // sigpulse model: trigger seen at an edge gives pulse_valid high for width cycles
  logic [W-1:0] sp_cnt;
  always @(posedge io_clk) begin
    if (io_rst)                sp_cnt <= '0;
    else if (sp_en)            sp_cnt <= sp_pulseWidth;
    else if (sp_cnt != '0)     sp_cnt <= sp_cnt - 1;
  end
  assign sp_pulseValid = (sp_cnt != '0);

  int cyc = 0;
  always @(posedge io_clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int idx;
    int from_start;
    int delay;
    int width;
    int level;
  } ev_t;
  ev_t q[$];

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic exp_ev(input int kind, input int idx, input int from_start,
                        input int delay, input int width, input int level);
    ev_t e;
    e.kind = kind; e.idx = idx; e.from_start = from_start;
    e.delay = delay; e.width = width; e.level = level;
    q.push_back(e);
  endtask

  // Monitor: reference points are the accepted-start sample and the last pulse_valid fall
  int start_cyc = -1000;
  int fall_cyc  = -1000;
  logic prev_pv = 1'b0;
  initial begin
    ev_t e;
    int kind;
    forever begin
      @(negedge io_clk);
      if (io_start && !io_busy) start_cyc = cyc;
      if (prev_pv && !sp_pulseValid) fall_cyc = cyc;
      prev_pv = sp_pulseValid;
      if (sp_en || io_done) begin
        kind = sp_en ? EV_EN : EV_DONE;
        chk(sp_en ? "event_expected_en" : "event_expected_done", int'(q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("event_kind", kind, e.kind);
          chk("event_idx", io_pulseIdx, e.idx);
          chk("event_delay", e.from_start != 0 ? cyc - start_cyc : cyc - fall_cyc, e.delay);
          if (kind == EV_EN) begin
            chk("en_width", sp_pulseWidth, e.width);
            chk("en_level", sp_defaultLevel, e.level);
          end else begin
            chk("done_busy_low", io_busy, 0);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge io_clk);
    #1;
  endtask

  task automatic start_burst(input int w, input int g, input int c, input int l);
    io_pulseWidth = W'(w); io_gap = W'(g); io_count = C'(c); io_defaultLevel = l[0];
    io_start = 1'b1;
    step();
    io_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (io_busy && k < budget) begin
      step();
      k++;
    end
    chk("idle_within_budget", io_busy, 0);
    step();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_sp_en"}, sp_en, 0);
    chk({tag, "_busy"}, io_busy, 0);
    chk({tag, "_done"}, io_done, 0);
    chk({tag, "_idx"}, io_pulseIdx, 0);
    chk({tag, "_sp_width"}, sp_pulseWidth, 0);
    chk({tag, "_sp_level"}, sp_defaultLevel, 0);
  endtask

  task automatic single_pulse_burst();
    exp_ev(EV_EN, 1, 1, 1, 100, 1);
    exp_ev(EV_DONE, 1, 0, 1, 0, 0);
    start_burst(100, 0, 1, 1);
    wait_idle(300);
    chk("single_idx", io_pulseIdx, 1);
    chk("single_queue_drained", q.size(), 0);
  endtask

  initial begin
    int k;
    repeat (3) step();
    check_reset_values("reset");
    io_rst = 1'b0;
    step();

    single_pulse_burst();

    // three pulses, gap 20: each trigger 21 cycles after pulse_valid falls
    exp_ev(EV_EN, 1, 1, 1, 10, 1);
    exp_ev(EV_EN, 2, 0, 21, 10, 1);
    exp_ev(EV_EN, 3, 0, 21, 10, 1);
    exp_ev(EV_DONE, 3, 0, 1, 0, 0);
    start_burst(10, 20, 3, 1);
    wait_idle(500);
    chk("burst3_idx", io_pulseIdx, 3);
    chk("burst3_queue_drained", q.size(), 0);

    // stop during the second pulse: drain, no done
    exp_ev(EV_EN, 1, 1, 1, 30, 0);
    exp_ev(EV_EN, 2, 0, 3, 30, 0);
    start_burst(30, 2, 5, 0);
    k = 0;
    while (!(io_pulseIdx == 2 && sp_pulseValid) && k < 200) begin
      step();
      k++;
    end
    chk("stop_reached_pulse2", int'(io_pulseIdx == 2 && sp_pulseValid), 1);
    step();
    io_stop = 1'b1;
    step();
    io_stop = 1'b0;
    chk("stop_drain_busy", io_busy, 1);
    wait_idle(100);
    chk("stop_idx", io_pulseIdx, 2);
    chk("stop_queue_drained", q.size(), 0);

    // start and stop together: start dropped
    io_pulseWidth = W'(10); io_gap = '0; io_count = C'(1); io_defaultLevel = 1'b0;
    io_start = 1'b1; io_stop = 1'b1;
    step();
    io_start = 1'b0; io_stop = 1'b0;
    repeat (2) step();
    chk("start_stop_busy", io_busy, 0);

    // start while busy is ignored and config outputs hold
    exp_ev(EV_EN, 1, 1, 1, 8, 0);
    exp_ev(EV_DONE, 1, 0, 1, 0, 0);
    start_burst(8, 0, 1, 0);
    repeat (3) step();
    io_pulseWidth = W'(50);
    io_start = 1'b1;
    step();
    io_start = 1'b0;
    wait_idle(100);
    chk("busy_start_idx", io_pulseIdx, 1);
    chk("busy_start_width_held", sp_pulseWidth, 8);

    // zero width is never accepted
    start_burst(0, 0, 2, 0);
    repeat (2) step();
    chk("width0_busy", io_busy, 0);

`ifdef SIGPULSE_SEQ_LOOP_EN
    exp_ev(EV_EN, 1, 1, 1, 4, 1);
    exp_ev(EV_EN, 2, 0, 1, 4, 1);
    exp_ev(EV_EN, 3, 0, 1, 4, 1);
    start_burst(4, 0, 0, 1);
    k = 0;
    while (io_pulseIdx != 3 && k < 100) begin
      step();
      k++;
    end
    chk("loop_reached_idx3", io_pulseIdx, 3);
    io_stop = 1'b1;
    step();
    io_stop = 1'b0;
    wait_idle(50);
    chk("loop_idx", io_pulseIdx, 3);
    chk("loop_queue_drained", q.size(), 0);
`else
    start_burst(5, 0, 0, 1);
    repeat (2) step();
    chk("count0_busy", io_busy, 0);
`endif

    // reset while in GAP
    exp_ev(EV_EN, 1, 1, 1, 5, 1);
    start_burst(5, 20, 3, 1);
    k = 0;
    while (!sp_pulseValid && k < 10) begin
      step();
      k++;
    end
    k = 0;
    while (sp_pulseValid && k < 20) begin
      step();
      k++;
    end
    chk("gap_reached", sp_pulseValid, 0);
    repeat (5) step();
    io_rst = 1'b1;
    step();
    check_reset_values("midreset");
    io_rst = 1'b0;
    chk("midreset_queue_drained", q.size(), 0);
    step();

    single_pulse_burst();

    repeat (3) step();
    chk("final_queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
